// File: rtl/pll_sup_pkg.sv
// rtl/pll_sup_pkg.sv - shared types and constants for the PLL lock supervisor
//
// Purpose: supervisor state encoding and relock counter width.
package pll_sup_pkg;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } pll_state_e;

    localparam int RELOCK_CNT_W = 8;

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - multi-flop synchroniser for a single asynchronous bit
//
// Purpose: brings an asynchronous level into the clk domain.
// Ports:
//   clk  - destination clock
//   rst  - asynchronous active-high reset, clears every stage to 0
//   d_i  - asynchronous input level
//   q_o  - synchronised level, SYNC_STAGES edges behind d_i
module sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift form keeps the chain legal even for a single stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= (sync_q << 1) | SYNC_STAGES'(d_i);
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset/lock handshake supervisor on refclk
//
// Purpose: resets the PLL, waits for its lock to be continuously stable,
// then releases the system reset; on lock loss re-resets everything and
// counts the event. Optional macro PLL_SUP_TIMEOUT_EN enables the
// WAIT_LOCK timeout that re-resets a PLL which never locks.
// Ports:
//   refclk       - free-running reference clock (only clock)
//   rst          - asynchronous active-high reset
//   locked_in    - PLL lock flag, asynchronous to refclk
//   pll_rst      - reset to the PLL, active-high
//   sys_rst      - system reset, active-high, low only in RUN
//   ready        - high only in RUN
//   lock_lost    - one-cycle pulse when lock drops in RUN
//   relock_count - lock losses from RUN, saturating at 255
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int SYNC_STAGES        = 2,
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES = 50000,
    parameter int RELOCK_TIMEOUT     = 500000
) (
    input  logic                    refclk,
    input  logic                    rst,
    input  logic                    locked_in,
    output logic                    pll_rst,
    output logic                    sys_rst,
    output logic                    ready,
    output logic                    lock_lost,
    output logic [RELOCK_CNT_W-1:0] relock_count
);

    localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                             PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_CYC = (MAX_AB > RELOCK_TIMEOUT) ? MAX_AB : RELOCK_TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
`ifdef PLL_SUP_TIMEOUT_EN
    localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(RELOCK_TIMEOUT - 1);
`endif
    localparam logic [RELOCK_CNT_W-1:0] RELOCK_MAX = '1;

    pll_state_e              state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    pll_rst_q;
    logic                    sys_rst_q;
    logic                    ready_q;
    logic                    lock_lost_q;
    logic [RELOCK_CNT_W-1:0] relock_q;
    logic                    sl;

    sync_bit #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk(refclk),
        .rst(rst),
        .d_i(locked_in),
        .q_o(sl)
    );

    // Single shared counter: cleared on every state entry, so each state
    // measures its own dwell time from zero.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q     <= PLL_RST;
            cnt_q       <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
            relock_q    <= '0;
        end else begin
            lock_lost_q <= 1'b0;
            case (state_q)
                PLL_RST: begin
                    // Lock flag is meaningless while the PLL is held in reset.
                    if (cnt_q == RST_LAST) begin
                        state_q   <= WAIT_LOCK;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (sl) begin
                        state_q <= STABLE;
                        cnt_q   <= '0;
                    end
`ifdef PLL_SUP_TIMEOUT_EN
                    else if (cnt_q == WAIT_LAST) begin
                        state_q   <= PLL_RST;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
`endif
                end
                STABLE: begin
                    // Any dropout restarts the qualification from WAIT_LOCK.
                    if (!sl) begin
                        state_q <= WAIT_LOCK;
                        cnt_q   <= '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_q   <= RUN;
                        cnt_q     <= '0;
                        sys_rst_q <= 1'b0;
                        ready_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!sl) begin
                        state_q     <= PLL_RST;
                        cnt_q       <= '0;
                        pll_rst_q   <= 1'b1;
                        sys_rst_q   <= 1'b1;
                        ready_q     <= 1'b0;
                        lock_lost_q <= 1'b1;
                        if (relock_q != RELOCK_MAX) begin
                            relock_q <= relock_q + RELOCK_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q   <= PLL_RST;
                    cnt_q     <= '0;
                    pll_rst_q <= 1'b1;
                    sys_rst_q <= 1'b1;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    assign pll_rst      = pll_rst_q;
    assign sys_rst      = sys_rst_q;
    assign ready        = ready_q;
    assign lock_lost    = lock_lost_q;
    assign relock_count = relock_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - directed self-checking bench for pll_lock_supervisor
module tb_pll_lock_supervisor;

    logic       refclk;
    logic       rst;
    logic       locked_in;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       lock_lost;
    logic [7:0] relock_count;

    int n_cmp;
    int n_err;

    pll_lock_supervisor #(
        .SYNC_STAGES(2),
        .PLL_RST_CYCLES(4),
        .LOCK_STABLE_CYCLES(8),
        .RELOCK_TIMEOUT(32)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .locked_in(locked_in),
        .pll_rst(pll_rst),
        .sys_rst(sys_rst),
        .ready(ready),
        .lock_lost(lock_lost),
        .relock_count(relock_count)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic test_reset();
        rst = 1'b1;
        locked_in = 1'b0;
        repeat (3) @(negedge refclk);
        n_cmp++; if (pll_rst !== 1'b1) begin n_err++; $display("FAIL reset_pll_rst got %b want 1", pll_rst); end
        n_cmp++; if (sys_rst !== 1'b1) begin n_err++; $display("FAIL reset_sys_rst got %b want 1", sys_rst); end
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", ready); end
        n_cmp++; if (lock_lost !== 1'b0) begin n_err++; $display("FAIL reset_lock_lost got %b want 0", lock_lost); end
        n_cmp++; if (relock_count !== 8'd0) begin n_err++; $display("FAIL reset_relock got %0d want 0", relock_count); end
    endtask

    task automatic test_power_up();
        int n;
        rst = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge refclk); n++;
            if (pll_rst === 1'b0) break;
        end
        n_cmp++; if (n != 4) begin n_err++; $display("FAIL pwr_pll_rst_len got %0d want 4", n); end
        repeat (2) @(negedge refclk);
        locked_in = 1'b1;
        n = 0;
        while (n < 40) begin
            @(negedge refclk); n++;
            if (sys_rst === 1'b0) break;
        end
        // Counted from the edge that first samples locked_in high (n=1).
        n_cmp++; if (n != 11) begin n_err++; $display("FAIL pwr_release_edge got %0d want 11", n); end
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL pwr_ready got %b want 1", ready); end
        n_cmp++; if (relock_count !== 8'd0) begin n_err++; $display("FAIL pwr_relock got %0d want 0", relock_count); end
    endtask

    task automatic test_loss();
        int n;
        int k;
        locked_in = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge refclk); n++;
            if (lock_lost === 1'b1) break;
        end
        n_cmp++; if (n < 3 || n > 4) begin n_err++; $display("FAIL loss_latency got %0d want 3..4", n); end
        n_cmp++; if (sys_rst !== 1'b1) begin n_err++; $display("FAIL loss_sys_rst got %b want 1", sys_rst); end
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL loss_ready got %b want 0", ready); end
        n_cmp++; if (pll_rst !== 1'b1) begin n_err++; $display("FAIL loss_pll_rst_rise got %b want 1", pll_rst); end
        @(negedge refclk);
        n_cmp++; if (lock_lost !== 1'b0) begin n_err++; $display("FAIL loss_pulse_width got %b want 0", lock_lost); end
        k = 1;
        while (k < 20) begin
            if (pll_rst === 1'b0) break;
            @(negedge refclk); k++;
        end
        n_cmp++; if (k != 4) begin n_err++; $display("FAIL loss_pll_rst_len got %0d want 4", k); end
        n_cmp++; if (relock_count !== 8'd1) begin n_err++; $display("FAIL loss_relock got %0d want 1", relock_count); end
    endtask

    task automatic test_chatter();
        int n;
        int bad;
        bad = 0;
        locked_in = 1'b1;
        repeat (5) begin
            @(negedge refclk);
            if (lock_lost !== 1'b0 || sys_rst !== 1'b1) bad++;
        end
        locked_in = 1'b0;
        @(negedge refclk);
        if (lock_lost !== 1'b0 || sys_rst !== 1'b1) bad++;
        locked_in = 1'b1;
        n = 0;
        while (n < 40) begin
            @(negedge refclk); n++;
            if (lock_lost !== 1'b0) bad++;
            if (sys_rst === 1'b0) break;
        end
        n_cmp++; if (n != 11) begin n_err++; $display("FAIL chatter_release_edge got %0d want 11", n); end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL chatter_early_or_pulse got %0d want 0", bad); end
        n_cmp++; if (relock_count !== 8'd1) begin n_err++; $display("FAIL chatter_relock got %0d want 1", relock_count); end
    endtask

    task automatic test_timeout();
        int n;
        int rises;
        int first;
        logic prev;
        locked_in = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge refclk); n++;
            if (lock_lost === 1'b1) break;
        end
        n_cmp++; if (lock_lost !== 1'b1) begin n_err++; $display("FAIL timeout_loss_seen got %b want 1", lock_lost); end
        rises = 0;
        first = -1;
        prev = 1'b1;
        for (int i = 1; i <= 80; i++) begin
            @(negedge refclk);
            if (pll_rst === 1'b1 && prev === 1'b0) begin
                rises++;
                if (first < 0) first = i;
            end
            prev = pll_rst;
        end
`ifdef PLL_SUP_TIMEOUT_EN
        n_cmp++; if (rises != 2) begin n_err++; $display("FAIL timeout_rises got %0d want 2", rises); end
        n_cmp++; if (first != 36) begin n_err++; $display("FAIL timeout_period got %0d want 36", first); end
`else
        n_cmp++; if (rises != 0) begin n_err++; $display("FAIL timeout_rises got %0d want 0", rises); end
        n_cmp++; if (pll_rst !== 1'b0) begin n_err++; $display("FAIL timeout_pll_rst_idle got %b want 0", pll_rst); end
`endif
        n_cmp++; if (relock_count !== 8'd2) begin n_err++; $display("FAIL timeout_relock got %0d want 2", relock_count); end
    endtask

    task automatic test_saturation();
        int n;
        int pulses;
        int exp_cnt;
        pulses = 0;
        for (int i = 0; i < 256; i++) begin
            locked_in = 1'b1;
            n = 0;
            while (n < 200 && ready !== 1'b1) begin @(negedge refclk); n++; end
            if (ready !== 1'b1) begin
                n_cmp++; n_err++;
                $display("FAIL sat_ready_timeout got iter %0d want ready", i);
                break;
            end
            locked_in = 1'b0;
            n = 0;
            while (n < 20 && lock_lost !== 1'b1) begin @(negedge refclk); n++; end
            if (lock_lost === 1'b1) pulses++;
            exp_cnt = (i + 3 > 255) ? 255 : i + 3;
            n_cmp++;
            if (relock_count !== exp_cnt[7:0]) begin
                n_err++;
                $display("FAIL sat_relock_iter%0d got %0d want %0d", i, relock_count, exp_cnt);
            end
        end
        n_cmp++; if (pulses != 256) begin n_err++; $display("FAIL sat_pulses got %0d want 256", pulses); end
        n_cmp++; if (relock_count !== 8'd255) begin n_err++; $display("FAIL sat_final got %0d want 255", relock_count); end
    endtask

    task automatic test_async_reset();
        int n;
        locked_in = 1'b1;
        n = 0;
        while (n < 20 && pll_rst !== 1'b0) begin @(negedge refclk); n++; end
        repeat (4) @(negedge refclk);
        n_cmp++; if (sys_rst !== 1'b1) begin n_err++; $display("FAIL arst_pre_sys_rst got %b want 1", sys_rst); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (pll_rst !== 1'b1) begin n_err++; $display("FAIL arst_pll_rst got %b want 1", pll_rst); end
        n_cmp++; if (sys_rst !== 1'b1) begin n_err++; $display("FAIL arst_sys_rst got %b want 1", sys_rst); end
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL arst_ready got %b want 0", ready); end
        n_cmp++; if (lock_lost !== 1'b0) begin n_err++; $display("FAIL arst_lock_lost got %b want 0", lock_lost); end
        n_cmp++; if (relock_count !== 8'd0) begin n_err++; $display("FAIL arst_relock got %0d want 0", relock_count); end
        repeat (2) @(negedge refclk);
        rst = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge refclk); n++;
            if (pll_rst === 1'b0) break;
        end
        n_cmp++; if (n != 4) begin n_err++; $display("FAIL arst_fresh_pll_rst_len got %0d want 4", n); end
        n_cmp++; if (relock_count !== 8'd0) begin n_err++; $display("FAIL arst_post_relock got %0d want 0", relock_count); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        locked_in = 1'b0;
        test_reset();
        test_power_up();
        test_loss();
        test_chatter();
        test_timeout();
        test_saturation();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
